uart_tx_queue: RTL and testbench

//  Byte FIFO and launch sequencer directly upstream of the UART transmitter.

---
 rtl/uart_tx_queue.sv | 104 ++++++++++
 tb/tb_uart_tx_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO and one-pulse-per-byte launch sequencer feeding a UART transmitter
// Optional flush port and logic enabled by defining UART_TXQ_FLUSH_EN.
module uart_tx_queue #(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
`ifdef UART_TXQ_FLUSH_EN
  input  logic          flush,
`endif
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [1:0]    state_q, state_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          flush_w;
  logic          push;
  logic          pop;

`ifdef UART_TXQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign in_ready = !full && !flush_w;
  assign push     = in_valid && in_ready;
  // A flush on the decision edge suppresses the launch entirely.
  assign pop      = (state_q == S_IDLE) && !empty && !tx_busy && !flush_w;

  assign level    = level_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    if (flush_w) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = pop;
    tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    case (state_q)
      S_IDLE:      if (pop)      state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy)  state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - scoreboard bench for uart_tx_queue with a simple UART busy model
// Flush scenario is exercised when UART_TXQ_FLUSH_EN is defined.
module tb_uart_tx_queue;

  localparam int FRAME = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       flush;
  logic       force_busy;
  int         model_cnt;

  int checks = 0;
  int errors = 0;
  int launches = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
`ifdef UART_TXQ_FLUSH_EN
    .flush    (flush),
`endif
    .level    (level),
    .empty    (empty),
    .full     (full)
  );

  // UART stand-in: samples tx_start only when idle, busy from the next cycle for FRAME cycles.
  assign tx_busy = force_busy || (model_cnt != 0);
  always @(posedge clk) begin
    if (rst)                                model_cnt <= 0;
    else if (model_cnt == 0 && !force_busy && tx_start) model_cnt <= FRAME;
    else if (model_cnt != 0)                model_cnt <= model_cnt - 1;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every launch must match the head of the scoreboard and never hit a busy UART.
  always @(negedge clk) begin
    if (!rst && tx_start) begin
      launches++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL launch_unexpected actual=%0h required=none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL launch_data actual=%0h required=%0h", tx_data, e);
        end
      end
      checks++;
      if (tx_busy) begin
        errors++;
        $display("FAIL launch_collision actual=busy required=idle");
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit exp_acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    check("in_ready", int'(in_ready), int'(exp_acc));
    if (exp_acc) exp_q.push_back(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && level == 5'd0 && !tx_busy && !tx_start) done = 1'b1;
    end
    check("drain_timeout", int'(done), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(posedge clk);
      #1;
      if (tx_busy) done = 1'b1;
    end
    check("busy_timeout", int'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    flush      = 1'b0;
    force_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data",  int'(tx_data),  0);
    check("rst_level",    int'(level),    0);
    check("rst_empty",    int'(empty),    1);
    check("rst_full",     int'(full),     0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk) rst = 1'b0;

    // Single byte: launch is sampled by the UART on the second edge after the push edge.
    l0 = launches;
    push_byte(8'hA5, 1'b1);
    check("lat_edge1_start", int'(tx_start), 0);
    @(posedge clk);
    #1;
    check("lat_edge2_start", int'(tx_start), 1);
    check("lat_edge2_data",  int'(tx_data),  8'hA5);
    repeat (25) @(posedge clk);
    #1;
    check("single_launches", launches - l0, 1);
    check("hold_tx_data",    int'(tx_data), 8'hA5);
    wait_idle(100);

    // Fill while the transmitter is held busy; write pointer wraps past index 15.
    @(negedge clk) force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    check("fill_level",    int'(level),    16);
    check("fill_full",     int'(full),     1);
    check("fill_empty",    int'(empty),    0);
    check("fill_in_ready", int'(in_ready), 0);
    push_byte(8'h10, 1'b0);
    check("refused_level", int'(level), 16);
    l0 = launches;
    @(negedge clk) force_busy = 1'b0;
    wait_idle(1000);
    check("fill_launches", launches - l0, 16);

    // Advance pointers to 14 so the concurrent case straddles the wrap.
    for (int i = 0; i < 13; i++) push_byte(8'h30 + 8'(i), 1'b1);
    wait_idle(1000);

    @(negedge clk) force_busy = 1'b1;
    push_byte(8'h20, 1'b1);
    push_byte(8'h21, 1'b1);
    push_byte(8'h22, 1'b1);
    @(negedge clk);
    force_busy = 1'b0;
    in_valid   = 1'b1;
    in_data    = 8'h23;
    check("conc_in_ready", int'(in_ready), 1);
    exp_q.push_back(8'h23);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("conc_level",    int'(level),    3);
    check("conc_tx_start", int'(tx_start), 1);
    wait_idle(1000);

    // Reset mid-frame with five bytes still queued.
    for (int i = 0; i < 6; i++) push_byte(8'h40 + 8'(i), 1'b1);
    wait_busy(50);
    @(posedge clk);
    #1;
    check("midframe_level", int'(level), 5);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_level",    int'(level),    0);
    check("midrst_tx_start", int'(tx_start), 0);
    check("midrst_empty",    int'(empty),    1);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk) rst = 1'b0;
    l0 = launches;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_launch", launches - l0, 0);

`ifdef UART_TXQ_FLUSH_EN
    // Flush during the 8'h11 frame: 11 completes, 22/33 are dropped, push under flush refused.
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    wait_busy(50);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h44;
    check("flush_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("flush_level", int'(level),   0);
    check("flush_empty", int'(empty),   1);
    check("flush_busy",  int'(tx_busy), 1);
    l0 = launches;
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_launch", launches - l0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
